hub75_bcm_driver: RTL
=====================

HUB75_BCM_DRIVER -- requirements
Module: hub75_bcm_driver

Interface
REQ-001 Parameter NUM_COLS, default 64, pixels shifted per line per half-panel.
REQ-002 Parameter SCAN_RATE, default 32, number of row addresses.
REQ-003 Parameter BIT_DEPTH, default 3, bits per colour channel (BCM planes).
REQ-004 Parameter BASE_PERIOD, default 100, display cycles of the LSB plane; plane p displays BASE_PERIOD<<p cycles.
REQ-005 clk_in  input  1  sole clock; all logic on posedge.
REQ-006 rst_in  input  1  synchronous, active-low reset.
REQ-007 column_data  input  [1:0][NUM_COLS-1:0][3*BIT_DEPTH-1:0]  half-panel 0/1 pixels; channel c (0=R,1=G,2=B), plane p at bit c*BIT_DEPTH+p.
REQ-008 col_index  input  $clog2(SCAN_RATE)  row address accompanying column_data.
REQ-009 tvalid  input  1  upstream data valid.
REQ-010 tready  output  1  block accepts column_data/col_index.
REQ-011 rgb0, rgb1  output  3 each  {B,G,R} bit of current plane, half-panel 0/1.
REQ-012 led_clk  output  1  registered shift clock (no clock gating).
REQ-013 led_latch  output  1  panel latch strobe.
REQ-014 led_output_enable  output  1  panel OE, active-low at panel (1 = blanked).
REQ-015 row_addr  output  $clog2(SCAN_RATE)  panel row address.
REQ-016 frame_done  output  1  one-cycle pulse after final plane of a column.

Function
REQ-017 States SHALL be IDLE, SHIFT, LATCH, DISPLAY.
REQ-018 Transfer SHALL occur on a cycle with tvalid&&tready; data and col_index captured into working buffer; next cycle state=SHIFT, plane=0, pixel=0, phase=0.
REQ-019 In SHIFT each pixel SHALL take 2 cycles: phase 0 led_clk=0 with rgb valid, phase 1 led_clk=1 with rgb unchanged; SHIFT lasts 2*NUM_COLS cycles.
REQ-020 rgbN[c] SHALL equal buffer[N][pixel][c*BIT_DEPTH+plane].
REQ-021 After phase 1 of pixel NUM_COLS-1, state SHALL go to LATCH for exactly one cycle: led_latch=1, led_clk=0, row_addr<=captured col_index.
REQ-022 DISPLAY SHALL hold led_output_enable=0 for exactly BASE_PERIOD<<plane cycles; led_output_enable=1 in all other states.
REQ-023 On DISPLAY end: plane<BIT_DEPTH-1 -> plane+1, SHIFT; plane==BIT_DEPTH-1 -> frame_done=1 for one cycle, IDLE.
REQ-024 Per-column cycle count SHALL be BIT_DEPTH*(2*NUM_COLS+1)+BASE_PERIOD*(2^BIT_DEPTH-1) excluding IDLE.
REQ-025 Period counter SHALL be wide enough for BASE_PERIOD<<(BIT_DEPTH-1) without wrap.
REQ-026 tvalid without tready SHALL be ignored; no data change while not accepted.
REQ-027 All outputs SHALL be registered except tready, which is decoded from state/buffer flags.

Reset
REQ-028 While rst_in=0: state=IDLE, tready=0, rgb0=rgb1=0, led_clk=0, led_latch=0, led_output_enable=1, row_addr=0, frame_done=0, counters=0.
REQ-029 Reset asserted mid-SHIFT/DISPLAY SHALL abort at the next edge with no further latch pulse; tready=1 on first cycle after release.

Configuration
REQ-030 Macro HUB75_DOUBLE_BUFFER_EN: defined -> shadow buffer added; tready=1 whenever shadow empty (any state); after final plane, if shadow full, shadow moves to working buffer and state goes directly to SHIFT (frame_done still pulses); simultaneous accept and shadow drain in the same cycle SHALL lose no data.
REQ-031 Macro undefined -> no shadow buffer; tready=1 only in IDLE.

Verification (NUM_COLS=4, BIT_DEPTH=3, BASE_PERIOD=2, SCAN_RATE=32)
REQ-032 Reset low 3 cycles, release -> outputs per REQ-028, tready=1 next cycle.
REQ-033 One transfer, col_index=5, pixel0 half0 R=3'b101 -> rgb0[0] sequence 1,0,1 across planes; 3 latch pulses; OE low runs 2,4,8; row_addr=5; frame_done after 41 cycles.
REQ-034 tvalid held high continuously, macro undefined -> 1-cycle IDLE gap between columns; macro defined -> second column SHIFT starts immediately after first DISPLAY end.
REQ-035 rst_in low during plane-1 DISPLAY -> OE=1 next edge, no further led_latch, clean restart.
REQ-036 tvalid pulsed during SHIFT, macro undefined -> ignored; led_clk toggles exactly 4 rising edges per SHIFT.

Source files
------------

// File: rtl/hub75_bcm_driver.sv
// HUB75 panel driver: shifts one captured column set per bit plane, latches it and
// displays it for a binary-weighted period. Define HUB75_DOUBLE_BUFFER_EN to add a shadow buffer.
module hub75_bcm_driver #(
  parameter int NUM_COLS    = 64,
  parameter int SCAN_RATE   = 32,
  parameter int BIT_DEPTH   = 3,
  parameter int BASE_PERIOD = 100
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic [1:0][NUM_COLS-1:0][3*BIT_DEPTH-1:0] column_data,
  input  logic [$clog2(SCAN_RATE)-1:0]            col_index,
  input  logic                                    tvalid,
  output logic                                    tready,
  output logic [2:0]                              rgb0,
  output logic [2:0]                              rgb1,
  output logic                                    led_clk,
  output logic                                    led_latch,
  output logic                                    led_output_enable,
  output logic [$clog2(SCAN_RATE)-1:0]            row_addr,
  output logic                                    frame_done
);

  localparam int AW    = $clog2(SCAN_RATE);
  localparam int DW    = 3 * BIT_DEPTH;
  localparam int PIX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int PL_W  = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
  localparam int BI_W  = (DW > 1) ? $clog2(DW) : 1;
  localparam int CNT_W = $clog2((BASE_PERIOD << (BIT_DEPTH - 1)) + 1);

  typedef logic [NUM_COLS-1:0][DW-1:0] half_t;
  typedef logic [1:0][NUM_COLS-1:0][DW-1:0] col_t;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t           state;
  logic             armed;
  logic [PL_W-1:0]  plane;
  logic [PIX_W-1:0] pixel;
  logic             phase;
  logic [CNT_W-1:0] cnt;
  col_t             wk_data;
  logic [AW-1:0]    wk_idx;

  logic             accept, disp_end, last_end, start;
  col_t             src_data;
  logic [AW-1:0]    src_idx;

  // {B,G,R} bits of one pixel for one plane
  function automatic logic [2:0] pick(input half_t h, input logic [PIX_W-1:0] px,
                                      input logic [PL_W-1:0] pl);
    logic [DW-1:0] w;
    logic [2:0]    r;
    w = h[px];
    for (int c = 0; c < 3; c++) r[c] = w[BI_W'(c * BIT_DEPTH) + BI_W'(pl)];
    return r;
  endfunction

  assign accept   = tvalid && tready;
  assign disp_end = (state == DISPLAY) && (cnt == '0);
  assign last_end = disp_end && (plane == PL_W'(BIT_DEPTH - 1));

`ifdef HUB75_DOUBLE_BUFFER_EN
  col_t          sh_data;
  logic [AW-1:0] sh_idx;
  logic          sh_full, drain, to_shadow;

  // A column arriving while busy parks in the shadow; at the end of the last plane
  // the shadow drains, or a same-cycle arrival goes straight to the working buffer.
  assign tready    = armed && !sh_full;
  assign drain     = last_end && sh_full;
  assign start     = drain || (accept && (state == IDLE || last_end));
  assign to_shadow = accept && !(state == IDLE || last_end);
  assign src_data  = drain ? sh_data : column_data;
  assign src_idx   = drain ? sh_idx  : col_index;

  always_ff @(posedge clk_in) begin
    if (!rst_in)        sh_full <= 1'b0;
    else if (to_shadow) sh_full <= 1'b1;
    else if (drain)     sh_full <= 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (to_shadow) begin
      sh_data <= column_data;
      sh_idx  <= col_index;
    end
  end
`else
  assign tready   = armed && (state == IDLE);
  assign start    = accept;
  assign src_data = column_data;
  assign src_idx  = col_index;
`endif

  always_ff @(posedge clk_in) begin
    if (start) begin
      wk_data <= src_data;
      wk_idx  <= src_idx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state             <= IDLE;
      armed             <= 1'b0;
      plane             <= '0;
      pixel             <= '0;
      phase             <= 1'b0;
      cnt               <= '0;
      rgb0              <= '0;
      rgb1              <= '0;
      led_clk           <= 1'b0;
      led_latch         <= 1'b0;
      led_output_enable <= 1'b1;
      row_addr          <= '0;
      frame_done        <= 1'b0;
    end else begin
      armed      <= 1'b1;
      led_latch  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: ;
        SHIFT: begin
          if (!phase) begin
            phase   <= 1'b1;
            led_clk <= 1'b1;
          end else begin
            phase   <= 1'b0;
            led_clk <= 1'b0;
            if (pixel == PIX_W'(NUM_COLS - 1)) begin
              state     <= LATCH;
              led_latch <= 1'b1;
              row_addr  <= wk_idx;
            end else begin
              pixel <= pixel + 1'b1;
              rgb0  <= pick(wk_data[0], pixel + 1'b1, plane);
              rgb1  <= pick(wk_data[1], pixel + 1'b1, plane);
            end
          end
        end
        LATCH: begin
          state             <= DISPLAY;
          led_output_enable <= 1'b0;
          cnt               <= CNT_W'((BASE_PERIOD << plane) - 1);
        end
        DISPLAY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            led_output_enable <= 1'b1;
            pixel             <= '0;
            phase             <= 1'b0;
            if (!last_end) begin
              state <= SHIFT;
              plane <= plane + 1'b1;
              rgb0  <= pick(wk_data[0], '0, plane + 1'b1);
              rgb1  <= pick(wk_data[1], '0, plane + 1'b1);
            end else begin
              state      <= IDLE;
              frame_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // a new column overrides whatever the case chose (IDLE or final display end)
      if (start) begin
        state   <= SHIFT;
        plane   <= '0;
        pixel   <= '0;
        phase   <= 1'b0;
        led_clk <= 1'b0;
        rgb0    <= pick(src_data[0], '0, '0);
        rgb1    <= pick(src_data[1], '0, '0);
      end
    end
  end

endmodule
